// File: rtl/johnson_pkg.sv
// Shared helpers for the Johnson (twisted-ring) counter family.
//   JC_MAX_W  : widest ring the helper functions can handle
//   jc_pw     : phase-index width for a given ring width
//   jc_encode : phase index -> ring code
//   jc_legal  : true when a ring code is one of the 2*width legal codes
package johnson_pkg;

  localparam int unsigned JC_MAX_W = 64;

  function automatic int unsigned jc_pw(input int unsigned width);
    return $clog2(2 * width);
  endfunction

  // Phases 0..width fill ones from the LSB; phases above width then
  // clear ones from the LSB while the upper bits stay set.
  function automatic logic [JC_MAX_W-1:0] jc_encode(input int unsigned phase,
                                                    input int unsigned width);
    logic [JC_MAX_W-1:0] r;
    if (phase <= width) begin
      r = (JC_MAX_W'(1) << phase) - JC_MAX_W'(1);
    end else begin
      r = ~((JC_MAX_W'(1) << (phase - width)) - JC_MAX_W'(1)) &
          ((JC_MAX_W'(1) << width) - JC_MAX_W'(1));
    end
    return r;
  endfunction

  // A legal code has at most one boundary between adjacent stages.
  function automatic logic jc_legal(input logic [JC_MAX_W-1:0] q,
                                    input int unsigned width);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i + 1 < width; i++) begin
      if (q[i] != q[i+1]) n++;
    end
    return (n <= 1);
  endfunction

endpackage

// File: rtl/johnson_ring_gen_phase_dec.sv
// Combinational decode of a Johnson ring code.
//   q     : ring register (WIDTH)
//   phase : binary phase index, 0 for an illegal code
//   dec   : one-hot phase decode (2*WIDTH), bit 0 for an illegal code
//   legal : q is one of the 2*WIDTH legal codes
module johnson_phase_dec
  import johnson_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int PW    = $clog2(2 * WIDTH)
) (
  input  logic [WIDTH-1:0]   q,
  output logic [PW-1:0]      phase,
  output logic [2*WIDTH-1:0] dec,
  output logic               legal
);

  localparam int unsigned NPH = 2 * WIDTH;

  int unsigned ones;

  always_comb begin
    ones = 0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      ones = ones + 32'(q[i]);
    end
    legal = jc_legal(JC_MAX_W'(q), WIDTH);
    // MSB clear: phase equals the ones count. MSB set: the ones shrink
    // from WIDTH as the phase climbs, so phase = 2*WIDTH - ones.
    if (!legal) begin
      phase = '0;
    end else if (q[WIDTH-1]) begin
      phase = PW'(NPH - ones);
    end else begin
      phase = PW'(ones);
    end
    dec = NPH'(1) << phase;
  end

endmodule

// File: rtl/johnson_ring_gen.sv
// Parametrised Johnson counter / multi-phase sequencer.
//   clk, rst_n     : clock, asynchronous active-low reset
//   en, dir        : step one phase per cycle, 0 = up, 1 = down
//   clr            : synchronous return to phase 0, clears err
//   load           : synchronous load of load_phase
//   load_phase     : target phase for load
//   q              : ring register
//   phase, dec     : binary and one-hot decode of q
//   wrap           : registered pulse, high while q shows the post-wrap phase
//   err            : sticky illegal-state / bad-load flag
module johnson_ring_gen
  import johnson_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int PW    = $clog2(2 * WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               dir,
  input  logic               clr,
  input  logic               load,
  input  logic [PW-1:0]      load_phase,
  output logic [WIDTH-1:0]   q,
  output logic [PW-1:0]      phase,
  output logic [2*WIDTH-1:0] dec,
  output logic               wrap,
  output logic               err
);

  localparam int unsigned NPH = 2 * WIDTH;

  logic [WIDTH-1:0] q_r, q_nxt;
  logic             err_r, err_nxt;
  logic             wrap_r, wrap_nxt;
  logic             q_legal;
  logic [PW-1:0]    ph;

  johnson_phase_dec #(
    .WIDTH (WIDTH),
    .PW    (PW)
  ) u_dec (
    .q     (q_r),
    .phase (ph),
    .dec   (dec),
    .legal (q_legal)
  );

  always_comb begin
    q_nxt    = q_r;
    err_nxt  = err_r;
    wrap_nxt = 1'b0;
    if (clr) begin
      q_nxt   = '0;
      err_nxt = 1'b0;
    end else if (load) begin
      if (32'(load_phase) < NPH) begin
        q_nxt = WIDTH'(jc_encode(32'(load_phase), WIDTH));
      end else begin
        err_nxt = 1'b1;
      end
    end else if (!q_legal) begin
      q_nxt   = '0;
      err_nxt = 1'b1;
    end else if (en) begin
      if (dir) begin
        q_nxt    = {~q_r[0], q_r[WIDTH-1:1]};
        wrap_nxt = (ph == '0);
      end else begin
        q_nxt    = {q_r[WIDTH-2:0], ~q_r[WIDTH-1]};
        wrap_nxt = (ph == PW'(NPH - 1));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r    <= '0;
      err_r  <= 1'b0;
      wrap_r <= 1'b0;
    end else begin
      q_r    <= q_nxt;
      err_r  <= err_nxt;
      wrap_r <= wrap_nxt;
    end
  end

  assign q     = q_r;
  assign phase = ph;
  assign wrap  = wrap_r;
  assign err   = err_r;

endmodule

// File: tb/tb_johnson_ring_gen.sv
module tb_johnson_ring_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // WIDTH = 4 instance (main sequence)
  logic a_en, a_dir, a_clr, a_load;
  logic [2:0] a_lp;
  logic [3:0] a_q;
  logic [2:0] a_ph;
  logic [7:0] a_dec;
  logic a_wrap, a_err;
  // WIDTH = 3 instance (out-of-range load is reachable)
  logic b_en, b_dir, b_clr, b_load;
  logic [2:0] b_lp;
  logic [2:0] b_q;
  logic [2:0] b_ph;
  logic [5:0] b_dec;
  logic b_wrap, b_err;
  // WIDTH = 2 and WIDTH = 16 full-period instances
  logic c_en, d_en;
  logic [1:0] c_q;
  logic [1:0] c_ph;
  logic [3:0] c_dec;
  logic c_wrap, c_err;
  logic [15:0] d_q;
  logic [4:0] d_ph;
  logic [31:0] d_dec;
  logic d_wrap, d_err;

  johnson_ring_gen #(.WIDTH(4)) u_a (
    .clk(clk), .rst_n(rst_n), .en(a_en), .dir(a_dir), .clr(a_clr), .load(a_load),
    .load_phase(a_lp), .q(a_q), .phase(a_ph), .dec(a_dec), .wrap(a_wrap), .err(a_err));
  johnson_ring_gen #(.WIDTH(3)) u_b (
    .clk(clk), .rst_n(rst_n), .en(b_en), .dir(b_dir), .clr(b_clr), .load(b_load),
    .load_phase(b_lp), .q(b_q), .phase(b_ph), .dec(b_dec), .wrap(b_wrap), .err(b_err));
  johnson_ring_gen #(.WIDTH(2)) u_c (
    .clk(clk), .rst_n(rst_n), .en(c_en), .dir(1'b0), .clr(1'b0), .load(1'b0),
    .load_phase(2'b00), .q(c_q), .phase(c_ph), .dec(c_dec), .wrap(c_wrap), .err(c_err));
  johnson_ring_gen #(.WIDTH(16)) u_d (
    .clk(clk), .rst_n(rst_n), .en(d_en), .dir(1'b0), .clr(1'b0), .load(1'b0),
    .load_phase(5'b00000), .q(d_q), .phase(d_ph), .dec(d_dec), .wrap(d_wrap), .err(d_err));

  typedef struct {
    int          dut;
    int          cyc;
    logic [15:0] q;
    int          ph;
    logic        wrap;
    logic        err;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic push(input int dut, input int dc, input logic [15:0] q, input int ph,
                      input logic w, input logic e, input string tag);
    exp_t x;
    x.dut = dut; x.cyc = cyc + dc; x.q = q; x.ph = ph;
    x.wrap = w; x.err = e; x.tag = tag;
    sb.push_back(x);
  endtask

  // Reference encoding straight from the phase definition.
  function automatic logic [15:0] mq(input int k, input int w);
    logic [31:0] r;
    if (k <= w) r = (32'd1 << k) - 32'd1;
    else        r = ~((32'd1 << (k - w)) - 32'd1) & ((32'd1 << w) - 32'd1);
    return r[15:0];
  endfunction

  // Monitor: every cycle the DUTs present outputs; compare any expectation due now.
  always @(negedge clk) begin
    exp_t e;
    logic [15:0] aq;
    logic [31:0] aph, adec;
    logic aw, ae;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      chk({e.tag, "/cyc"}, 32'(cyc), 32'(e.cyc));
      case (e.dut)
        0: begin aq = 16'(a_q); aph = 32'(a_ph); adec = 32'(a_dec); aw = a_wrap; ae = a_err; end
        1: begin aq = 16'(b_q); aph = 32'(b_ph); adec = 32'(b_dec); aw = b_wrap; ae = b_err; end
        2: begin aq = 16'(c_q); aph = 32'(c_ph); adec = 32'(c_dec); aw = c_wrap; ae = c_err; end
        default: begin aq = d_q; aph = 32'(d_ph); adec = d_dec; aw = d_wrap; ae = d_err; end
      endcase
      chk({e.tag, "/q"}, 32'(aq), 32'(e.q));
      chk({e.tag, "/phase"}, aph, 32'(e.ph));
      chk({e.tag, "/dec"}, adec, 32'd1 << e.ph);
      chk({e.tag, "/wrap"}, 32'(aw), 32'(e.wrap));
      chk({e.tag, "/err"}, 32'(ae), 32'(e.err));
    end
  end

  task automatic a_step(input logic en, input logic dir, input logic clr, input logic load,
                        input logic [2:0] lp, input logic [3:0] q, input int ph,
                        input logic w, input logic e, input string tag);
    a_en = en; a_dir = dir; a_clr = clr; a_load = load; a_lp = lp;
    push(0, 1, 16'(q), ph, w, e, tag);
    @(posedge clk); #1;
  endtask

  task automatic b_step(input logic en, input logic dir, input logic clr, input logic load,
                        input logic [2:0] lp, input logic [2:0] q, input int ph,
                        input logic w, input logic e, input string tag);
    b_en = en; b_dir = dir; b_clr = clr; b_load = load; b_lp = lp;
    push(1, 1, 16'(q), ph, w, e, tag);
    @(posedge clk); #1;
  endtask

  // Deposit an illegal code between edges, then expect correction at the next edge.
  task automatic illegal(input logic [3:0] v, input logic en, input string tag);
    @(negedge clk); #1;
    force u_a.q_r = v;
    #1 release u_a.q_r;
    chk({tag, "/ill_phase"}, 32'(a_ph), 32'd0);
    chk({tag, "/ill_dec"}, 32'(a_dec), 32'd1);
    a_en = en; a_dir = 1'b0; a_clr = 1'b0; a_load = 1'b0; a_lp = 3'd0;
    push(0, 1, 16'h0000, 0, 1'b0, 1'b1, tag);
    @(posedge clk); #1;
  endtask

  logic [3:0] up_q [9] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110,
                           4'b1100, 4'b1000, 4'b0000, 4'b0001};
  int up_ph [9] = '{1, 2, 3, 4, 5, 6, 7, 0, 1};

  initial begin
    rst_n = 1'b0;
    a_en = 0; a_dir = 0; a_clr = 0; a_load = 0; a_lp = '0;
    b_en = 0; b_dir = 0; b_clr = 0; b_load = 0; b_lp = '0;
    c_en = 0; d_en = 0;
    #2;
    chk("rst/q", 32'(a_q), 32'd0);
    chk("rst/phase", 32'(a_ph), 32'd0);
    chk("rst/dec", 32'(a_dec), 32'd1);
    chk("rst/wrap", 32'(a_wrap), 32'd0);
    chk("rst/err", 32'(a_err), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 9; i++)
      a_step(1, 0, 0, 0, 0, up_q[i], up_ph[i], (i == 7), 0, $sformatf("up%0d", i));

    a_step(0, 0, 1, 0, 0, 4'b0000, 0, 0, 0, "clr0");
    a_step(1, 1, 0, 0, 0, 4'b1000, 7, 1, 0, "dn_wrap");
    a_step(1, 1, 0, 0, 0, 4'b1100, 6, 0, 0, "dn6");
    a_step(1, 0, 0, 0, 0, 4'b1000, 7, 0, 0, "dir_flip");
    a_step(0, 0, 0, 1, 5, 4'b1110, 5, 0, 0, "load5");
    a_step(1, 0, 0, 1, 2, 4'b0011, 2, 0, 0, "load_en");
    a_step(0, 0, 1, 0, 0, 4'b0000, 0, 0, 0, "clr1");
    a_step(0, 0, 0, 1, 3, 4'b0111, 3, 0, 0, "load3");
    a_step(1, 0, 1, 1, 5, 4'b0000, 0, 0, 0, "clr_load_en");

    illegal(4'b0101, 1'b0, "ill0");
    a_step(1, 0, 0, 0, 0, 4'b0001, 1, 0, 1, "err_hold1");
    a_step(1, 0, 0, 0, 0, 4'b0011, 2, 0, 1, "err_hold2");
    illegal(4'b1001, 1'b1, "ill_en");
    a_step(0, 0, 1, 0, 0, 4'b0000, 0, 0, 0, "clr_err");
    a_step(0, 0, 0, 1, 6, 4'b1100, 6, 0, 0, "load6");

    // Asynchronous reset in the middle of a cycle at phase 6.
    @(negedge clk); #1;
    a_en = 1'b1; a_load = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst/q", 32'(a_q), 32'd0);
    chk("mid_rst/phase", 32'(a_ph), 32'd0);
    chk("mid_rst/dec", 32'(a_dec), 32'd1);
    chk("mid_rst/wrap", 32'(a_wrap), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    a_step(1, 0, 0, 0, 0, 4'b0001, 1, 0, 0, "post_rst");
    a_step(0, 0, 0, 0, 0, 4'b0001, 1, 0, 0, "hold");

    b_step(0, 0, 0, 1, 6, 3'b000, 0, 0, 1, "b_bad6");
    b_step(0, 0, 0, 1, 7, 3'b000, 0, 0, 1, "b_bad7");
    b_step(0, 0, 0, 1, 5, 3'b100, 5, 0, 1, "b_load5");
    b_step(1, 1, 0, 0, 0, 3'b110, 4, 0, 1, "b_dn4");
    b_step(0, 0, 1, 0, 0, 3'b000, 0, 0, 0, "b_clr");

    for (int i = 0; i < 33; i++) begin
      c_en = (i < 5);
      d_en = 1'b1;
      if (i < 5) push(2, 1, mq((i + 1) % 4, 2), (i + 1) % 4, ((i + 1) % 4) == 0, 0,
                      $sformatf("w2_%0d", i));
      push(3, 1, mq((i + 1) % 32, 16), (i + 1) % 32, ((i + 1) % 32) == 0, 0,
           $sformatf("w16_%0d", i));
      @(posedge clk); #1;
    end
    c_en = 0; d_en = 0;

    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
